// File: rtl/umi_mem_agent.sv
// Bridges UMI read/write requests onto a single-beat native memory port and
// returns read responses as UMI packets; writes are posted.
module umi_mem_agent #(
  parameter int unsigned TIMEOUT     = 1024,
  parameter logic [7:0]  RESP_OPCODE = 8'h03
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [255:0] umi_packet_rx,
  input  logic         umi_valid_rx,
  output logic         umi_ready_rx,
  output logic [255:0] umi_packet_tx,
  output logic         umi_valid_tx,
  input  logic         umi_ready_tx,
  output logic         mem_valid,
  input  logic         mem_ready,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_wstrb,
  input  logic [31:0]  mem_rdata,
  output logic         err_opcode,
  output logic         err_timeout
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [7:0] OpWrite = 8'h01;
  localparam logic [7:0] OpRead  = 8'h02;

  typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

  state_e          state_q, state_d;
  logic            write_q, write_d;
  logic [63:0]     dst_q, dst_d;
  logic [63:0]     src_q, src_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_opcode_q, err_opcode_d;
  logic            err_timeout_q, err_timeout_d;

  logic [7:0] rx_opcode;
  assign rx_opcode = umi_packet_rx[7:0];

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    dst_d         = dst_q;
    src_d         = src_q;
    data_d        = data_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;
    err_opcode_d  = err_opcode_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      StIdle: begin
        if (umi_valid_rx && umi_ready_rx) begin
          if (rx_opcode == OpWrite || rx_opcode == OpRead) begin
            write_d = (rx_opcode == OpWrite);
            dst_d   = umi_packet_rx[79:16];
            src_d   = umi_packet_rx[143:80];
            data_d  = umi_packet_rx[175:144];
            cnt_d   = '0;
            state_d = StMem;
          end else begin
            err_opcode_d = 1'b1;
          end
        end
      end
      StMem: begin
        // A ready in the last allowed cycle still wins over the abort.
        if (mem_ready) begin
          if (write_q) begin
            state_d = StIdle;
          end else begin
            rdata_d = mem_rdata;
            state_d = StResp;
          end
        end else if (cnt_q == CntLast) begin
          err_timeout_d = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (umi_ready_tx) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= StIdle;
      write_q       <= 1'b0;
      dst_q         <= '0;
      src_q         <= '0;
      data_q        <= '0;
      rdata_q       <= '0;
      cnt_q         <= '0;
      err_opcode_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      dst_q         <= dst_d;
      src_q         <= src_d;
      data_q        <= data_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
      err_opcode_q  <= err_opcode_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Ready is masked by reset so upstream sees no acceptance while held in reset.
  assign umi_ready_rx = (state_q == StIdle) && nreset;
  assign mem_valid    = (state_q == StMem);
  assign mem_addr     = {dst_q[31:2], 2'b00};
  assign mem_wdata    = data_q;
  assign mem_wstrb    = (mem_valid && write_q) ? 4'hF : 4'h0;
  assign umi_valid_tx = (state_q == StResp);
  assign err_opcode   = err_opcode_q;
  assign err_timeout  = err_timeout_q;

  always_comb begin
    umi_packet_tx = '0;
    if (state_q == StResp) begin
      umi_packet_tx[7:0]     = RESP_OPCODE;
      umi_packet_tx[79:16]   = src_q;
      umi_packet_tx[143:80]  = dst_q;
      umi_packet_tx[175:144] = rdata_q;
    end
  end

endmodule

// File: doc/umi_mem_agent.md
UMI_MEM_AGENT -- requirements
Module: umi_mem_agent

Interface
REQ-001 Parameter TIMEOUT, default 1024: maximum cycles a memory access may wait for mem_ready before abort.
REQ-002 Parameter RESP_OPCODE, default 8'h03: opcode placed in read-response packets.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port nreset, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port umi_packet_rx, input, 256: request packet from the UMI RX port.
REQ-006 Port umi_valid_rx, input, 1: request packet valid.
REQ-007 Port umi_ready_rx, output, 1: agent accepts a request.
REQ-008 Port umi_packet_tx, output, 256: response packet to the UMI TX port.
REQ-009 Port umi_valid_tx, output, 1: response valid.
REQ-010 Port umi_ready_tx, input, 1: downstream accepts the response.
REQ-011 Port mem_valid, output, 1: memory request valid (native core memory port style).
REQ-012 Port mem_ready, input, 1: memory completes the access this cycle.
REQ-013 Port mem_addr, output, 32: word-aligned byte address.
REQ-014 Port mem_wdata, output, 32: write data.
REQ-015 Port mem_wstrb, output, 4: byte strobes; 4'hF write, 4'h0 read.
REQ-016 Port mem_rdata, input, 32: read data, valid when mem_ready=1.
REQ-017 Port err_opcode, output, 1: sticky, unknown opcode seen.
REQ-018 Port err_timeout, output, 1: sticky, memory timeout seen.

Function
REQ-019 Packet fields SHALL be: opcode [7:0] (8'h01 write, 8'h02 read), dstaddr [79:16], srcaddr [143:80], data [175:144]; other bits ignored on RX.
REQ-020 The FSM SHALL have states IDLE, MEM, RESP; umi_ready_rx SHALL equal 1 only in IDLE.
REQ-021 A handshake (umi_valid_rx & umi_ready_rx) SHALL register the packet; opcode 01/02 -> MEM next cycle; any other opcode -> stay IDLE, packet dropped, err_opcode set.
REQ-022 In MEM: mem_valid=1, mem_addr={dstaddr[31:2],2'b00}, mem_wdata=data, mem_wstrb=4'hF (write) or 4'h0 (read), all stable until completion or abort.
REQ-023 Write completion (mem_ready=1 in MEM) SHALL return to IDLE; writes are posted, no response.
REQ-024 Read completion SHALL capture mem_rdata and enter RESP next cycle.
REQ-025 In RESP: umi_valid_tx=1; umi_packet_tx = opcode RESP_OPCODE, dstaddr = request srcaddr, srcaddr = request dstaddr, data = captured rdata, all other bits 0; held stable until umi_ready_tx=1, then IDLE.
REQ-026 A wait counter SHALL clear on entry to MEM and increment each MEM cycle without mem_ready; mem_ready arriving in the cycle the count reaches TIMEOUT-1 SHALL still complete normally; if the count reaches TIMEOUT-1 with mem_ready=0, the FSM SHALL deassert mem_valid, set err_timeout, return to IDLE, and send no response.
REQ-027 Minimum latency: request handshake cycle N -> mem_valid at N+1; mem_ready at N+1 -> umi_valid_tx at N+2.
REQ-028 Back-to-back requests: next request accepted no earlier than the cycle after return to IDLE; umi_valid_rx while not IDLE SHALL be ignored (not dropped, held upstream).
REQ-029 err_opcode/err_timeout SHALL stay 1 until reset.

Reset
REQ-030 nreset=0 SHALL immediately force IDLE, umi_ready_rx=0 during reset then 1 after release, umi_valid_tx=0, mem_valid=0, mem_wstrb=0, umi_packet_tx=0, err flags=0, wait counter=0.
REQ-031 Reset asserted mid-access or mid-response SHALL abandon the transaction; no response issued after release.

Verification
REQ-032 Write 0x01, dstaddr 0x104, data 0xDEADBEEF, mem_ready after 3 cycles -> mem_addr 0x104, wstrb F, wdata DEADBEEF for 4 cycles, no TX.
REQ-033 Read 0x02, dstaddr 0x106, srcaddr 0x55, mem_rdata 0x12345678 -> mem_addr 0x104, TX opcode 03, dstaddr 0x55, srcaddr 0x106, data 0x12345678.
REQ-034 Read response with umi_ready_tx low 5 cycles -> umi_valid_tx and packet stable 6 cycles; umi_ready_rx 0 throughout.
REQ-035 Opcode 0x7F -> no mem_valid, err_opcode=1, next valid request served normally.
REQ-036 TIMEOUT=8, mem_ready never -> mem_valid high exactly 8 cycles, err_timeout=1, no TX, IDLE after.
REQ-037 nreset pulsed while in RESP -> umi_valid_tx 0 immediately, no response after release.
